// File: rtl/types_pkg.sv
// Shared types for the select_action datapath and its sequencer.
// Holds the operand word, the operation modes, the sequencer state encoding
// and a helper that steps to the next operation mode with wrap-around.
package types_pkg;

    typedef logic [15:0] word_t;

    typedef enum logic [1:0] {
        ADD,
        SUB,
        SHL,
        SHR
    } opr_mode_t;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SETTLE,
        CAPTURE
    } seq_state_t;

    localparam int DEFAULT_SETTLE_CYCLES = 2;

    localparam opr_mode_t FIRST_MODE = ADD;
    localparam opr_mode_t LAST_MODE  = SHR;

    // Next operation in enumeration order; the last one wraps to the first.
    function automatic opr_mode_t next_mode(input opr_mode_t m);
        if (m == LAST_MODE) begin
            return FIRST_MODE;
        end
        return opr_mode_t'(m + 2'd1);
    endfunction

endpackage

// File: rtl/action_sequencer_scan_timer.sv
// scan_timer: idle-period counter for the auto-stepping build (AUTO_STEP_EN).
// Counts enabled cycles 0..PERIOD-1; on the cycle the count reaches its last
// value it raises a registered expire flag that stays high until cleared.
module scan_timer #(
    parameter int PERIOD = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic clear,
    output logic expire
);

    localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

    logic [CW-1:0] count_reg;

    // Period counter; expire latches at terminal count and holds until clear.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count_reg <= '0;
            expire    <= 1'b0;
        end else if (enable) begin
            if (count_reg == LAST) begin
                count_reg <= '0;
                expire    <= 1'b1;
            end else begin
                count_reg <= count_reg + 1'b1;
            end
        end
    end

endmodule

// File: rtl/action_sequencer.sv
// action_sequencer: runs one select_action operation per request.
// Latches mode/switch word, drives SELECTOR/SW, waits SETTLE_CYCLES, then
// registers LED and pulses done. Define AUTO_STEP_EN to let the block
// self-issue requests every SCAN_PERIOD idle cycles, stepping the mode.
module action_sequencer
    import types_pkg::*;
#(
    parameter int BITS          = 16,
    parameter int SETTLE_CYCLES = DEFAULT_SETTLE_CYCLES,
    parameter int SCAN_PERIOD   = 1000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  opr_mode_t       mode_in,
    input  logic [BITS-1:0] sw_in,
    input  logic            auto_en,
    output opr_mode_t       sel_o,
    output logic [BITS-1:0] sw_o,
    input  logic [BITS-1:0] led_i,
    output logic            busy,
    output logic            done,
    output logic [BITS-1:0] led_out,
    output opr_mode_t       mode_out
);

    localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

    seq_state_t       state_reg;
    logic [CNT_W-1:0] settle_cnt_reg;
    logic             auto_fire;

`ifdef AUTO_STEP_EN
    logic scan_enable;
    logic scan_clear;
    logic scan_expire;

    // Count only idle cycles with no external request; any accept restarts the period.
    assign scan_enable = (state_reg == IDLE) && auto_en && !start;
    assign scan_clear  = !auto_en || ((state_reg == IDLE) && (start || scan_expire));
    assign auto_fire   = scan_expire && auto_en;

    scan_timer #(
        .PERIOD (SCAN_PERIOD)
    ) u_scan_timer (
        .clk    (clk),
        .rst    (rst),
        .enable (scan_enable),
        .clear  (scan_clear),
        .expire (scan_expire)
    );
`else
    logic unused_cfg;

    // Without auto-stepping only start issues requests.
    assign auto_fire  = 1'b0;
    assign unused_cfg = auto_en & (SCAN_PERIOD > 0);
`endif

    // Request FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            sel_o          <= ADD;
            sw_o           <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            led_out        <= '0;
            mode_out       <= ADD;
            settle_cnt_reg <= '0;
        end else begin
            done <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        sel_o     <= mode_in;
                        sw_o      <= sw_in;
                        busy      <= 1'b1;
                        state_reg <= LOAD;
                    end else if (auto_fire) begin
                        sel_o     <= next_mode(mode_out);
                        sw_o      <= sw_in;
                        busy      <= 1'b1;
                        state_reg <= LOAD;
                    end
                end
                LOAD: begin
                    settle_cnt_reg <= '0;
                    state_reg      <= SETTLE;
                end
                SETTLE: begin
                    if (settle_cnt_reg == SETTLE_LAST) begin
                        state_reg <= CAPTURE;
                    end else begin
                        settle_cnt_reg <= settle_cnt_reg + 1'b1;
                    end
                end
                CAPTURE: begin
                    led_out   <= led_i;
                    mode_out  <= sel_o;
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_action_sequencer.sv
// Testbench for action_sequencer with a scoreboard: stimulus pushes the
// expected completion (cycle, LED, mode, switch word) and a negedge monitor
// pops and compares on every done pulse. The LED stub is led_base ^ sw_o.
module tb_action_sequencer;
    import types_pkg::*;

    localparam int BITS   = 16;
    localparam int SETTLE = 2;
    localparam int SCAN   = 4;

    logic      clk = 1'b0;
    logic      rst;
    logic      start;
    logic      auto_en;
    opr_mode_t mode_in;
    opr_mode_t sel_o;
    opr_mode_t mode_out;
    logic [BITS-1:0] sw_in;
    logic [BITS-1:0] sw_o;
    logic [BITS-1:0] led_i;
    logic [BITS-1:0] led_out;
    logic [BITS-1:0] led_base;
    logic busy;
    logic done;

    int unsigned cyc = 0;
    int unsigned vectors = 0;
    int unsigned miscompares = 0;

    typedef struct {
        int unsigned     cyc;
        logic [BITS-1:0] led;
        opr_mode_t       mode;
        logic [BITS-1:0] sw;
    } exp_t;

    exp_t exp_q[$];

    assign led_i = led_base ^ sw_o;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    action_sequencer #(
        .BITS          (BITS),
        .SETTLE_CYCLES (SETTLE),
        .SCAN_PERIOD   (SCAN)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .mode_in  (mode_in),
        .sw_in    (sw_in),
        .auto_en  (auto_en),
        .sel_o    (sel_o),
        .sw_o     (sw_o),
        .led_i    (led_i),
        .busy     (busy),
        .done     (done),
        .led_out  (led_out),
        .mode_out (mode_out)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_done(input int unsigned c, input logic [BITS-1:0] led,
                               input opr_mode_t m, input logic [BITS-1:0] sw);
        exp_t e;
        e.cyc  = c;
        e.led  = led;
        e.mode = m;
        e.sw   = sw;
        exp_q.push_back(e);
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick(1);
            n++;
        end
        check("queue_drained", exp_q.size(), 0);
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d, required no done", cyc);
            end else begin
                e = exp_q.pop_front();
                check("done_cycle", cyc, e.cyc);
                check("led_out", 32'(led_out), 32'(e.led));
                check("mode_out", 32'(mode_out), 32'(e.mode));
                check("sel_o_at_done", 32'(sel_o), 32'(e.mode));
                check("sw_o_at_done", 32'(sw_o), 32'(e.sw));
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int unsigned b;
        opr_mode_t auto_modes [5];

        rst      = 1'b1;
        start    = 1'b0;
        auto_en  = 1'b0;
        mode_in  = ADD;
        sw_in    = '0;
        led_base = '0;

        // 1: reset state
        tick(2);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_led_out", 32'(led_out), 0);
        check("rst_sel_o", 32'(sel_o), 32'(ADD));
        check("rst_sw_o", 32'(sw_o), 0);
        check("rst_mode_out", 32'(mode_out), 32'(ADD));
        rst = 1'b0;
        tick(1);

        // 2: single ADD request, LED stub yields 16'hA5A5
        b        = cyc;
        led_base = 16'hA5A0;
        mode_in  = ADD;
        sw_in    = 16'd5;
        start    = 1'b1;
        expect_done(b + 5, 16'hA5A5, ADD, 16'd5);
        tick(1);
        start = 1'b0;
        check("op_busy", 32'(busy), 1);
        check("op_sw_o", 32'(sw_o), 5);
        check("op_sel_o", 32'(sel_o), 32'(ADD));
        check("op_done_early", 32'(done), 0);

        // 3: start while busy is dropped
        tick(1);
        sw_in = 16'd9;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(6);
        check("drop_sw_o", 32'(sw_o), 5);
        check("drop_busy", 32'(busy), 0);
        check("drop_led_out", 32'(led_out), 32'hA5A5);

        // 4: reset during SETTLE aborts without done
        mode_in = SHL;
        sw_in   = 16'h0044;
        start   = 1'b1;
        tick(1);
        start = 1'b0;
        tick(1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("abort_led_out", 32'(led_out), 0);
        check("abort_busy", 32'(busy), 0);
        check("abort_sw_o", 32'(sw_o), 0);
        check("abort_done", 32'(done), 0);
        tick(8);
        check("abort_idle_busy", 32'(busy), 0);

        // 5: start held high, three requests, done every 5 cycles
        b        = cyc;
        led_base = 16'h1200;
        mode_in  = SUB;
        sw_in    = 16'h0031;
        start    = 1'b1;
        expect_done(b + 5, 16'h1231, SUB, 16'h0031);
        tick(2);
        mode_in = SHL;
        sw_in   = 16'h0032;
        expect_done(b + 10, 16'h1232, SHL, 16'h0032);
        tick(5);
        mode_in = SHR;
        sw_in   = 16'h0033;
        expect_done(b + 15, 16'h1233, SHR, 16'h0033);
        tick(5);
        start = 1'b0;
        drain(40);
        check("b2b_sw_hold", 32'(sw_o), 32'h0033);

`ifdef AUTO_STEP_EN
        // 6: auto-stepping, one request every 4+5 cycles, modes wrap
        rst = 1'b1;
        tick(1);
        rst      = 1'b0;
        b        = cyc;
        auto_en  = 1'b1;
        sw_in    = 16'h0007;
        led_base = 16'h3C00;
        auto_modes = '{SUB, SHL, SHR, ADD, SUB};
        for (int k = 0; k < 5; k++) begin
            expect_done(b + 9 + 9 * k, 16'h3C07, auto_modes[k], 16'h0007);
        end
        drain(80);
        auto_en = 1'b0;
        tick(30);
        check("auto_off_busy", 32'(busy), 0);
`else
        // 6: auto_en is ignored when auto-stepping is not built in
        auto_en = 1'b1;
        tick(30);
        auto_en = 1'b0;
        check("auto_ignored_busy", 32'(busy), 0);
        check("auto_ignored_led", 32'(led_out), 32'h1233);
`endif
        check("final_queue_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
